vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
// - Parametrised VGA timing generator. Produces pixel counters, blanking and sync for any mode.
// - Adds per-axis sync polarity, a pixel clock-enable, and line/frame start strobes.
// - Sits at the head of the video pipeline; all draw stages consume its registered outputs.
// - Default parameters give 800x600@60 (40 MHz pixel rate).
// PARAMETERS
// - CNT_W        11    counter width; H_TOTAL and V_TOTAL must both be <= 2**CNT_W
// - H_ACTIVE     800   visible pixels per line
// - H_SYNC_START 840   hcount at which hsync asserts
// - H_SYNC_END   968   hcount at which hsync deasserts (exclusive)
// - H_TOTAL      1056  pixels per line; hcount wraps at H_TOTAL-1
// - V_ACTIVE     600   visible lines
// - V_SYNC_START 601   vcount at which vsync asserts
// - V_SYNC_END   605   vcount at which vsync deasserts (exclusive)
// - V_TOTAL      628   lines per frame
// - H_SYNC_POL   1     1 = active-high hsync, 0 = active-low
// - V_SYNC_POL   1     1 = active-high vsync, 0 = active-low
// PORTS
// - clk          in   1      system clock
// - rst          in   1      asynchronous, active-high reset
// - ce           in   1      pixel enable; counters advance only on clk edges with ce=1
// - hcount       out  CNT_W  current pixel column
// - vcount       out  CNT_W  current line
// - hblnk        out  1      1 while hcount >= H_ACTIVE
// - vblnk        out  1      1 while vcount >= V_ACTIVE
// - hsync        out  1      horizontal sync, polarity per H_SYNC_POL
// - vsync        out  1      vertical sync, polarity per V_SYNC_POL
// - line_start   out  1      1 for exactly one ce-cycle when hcount==0
// - frame_start  out  1      1 for exactly one ce-cycle when hcount==0 and vcount==0
// BEHAVIOUR
// - Reset (async assert, released on clk): hcount=0, vcount=0, hblnk=0, vblnk=0,
//   hsync=~H_SYNC_POL, vsync=~V_SYNC_POL, line_start=0, frame_start=0.
// - All outputs are registered. On each clk edge with ce=1, next counts are computed and
//   every flag is decoded from the NEXT counts and registered with them. Flags therefore
//   always describe the hcount/vcount presented in the same cycle (zero relative latency).
// - After reset release, the first ce=1 edge presents (0,0) with line_start=frame_start=1.
// - Horizontal: hcount increments by 1. At H_TOTAL-1 it wraps to 0.
// - Vertical: vcount increments only on horizontal wrap. At V_TOTAL-1 it wraps to 0
//   on the same edge hcount wraps.
// - hsync is active for H_SYNC_START <= hcount < H_SYNC_END. vsync is active for
//   V_SYNC_START <= vcount < V_SYNC_END. Both are gated by polarity.
// - ce=0: every output register holds its value. Strobes are not re-emitted and are not
//   stretched by the enable: a held strobe stays high until the next ce=1 edge, where it clears.
// - Reset asserted mid-frame: outputs return to reset values at once (async). Counting
//   restarts at (0,0) with strobes, as after power-up.
// - Counter arithmetic is unsigned CNT_W. Compare ranges use half-open intervals.
// - Elaboration check ($error): require
//   H_ACTIVE < H_SYNC_START < H_SYNC_END <= H_TOTAL <= 2**CNT_W, and the same ordering vertically.
// STRUCTURE
// - vga_pkg holds the per-mode timing constants (800x600@60 defaults, 1024x768@60 set)
//   and a packed struct vga_timing_t {hcount, vcount, hblnk, vblnk, hsync, vsync}.
//   Downstream stages use this struct.
// - One sub-module: vga_axis_counter (params TOTAL, ACTIVE, SYNC_START, SYNC_END, POL, CNT_W;
//   inputs inc; outputs count, blnk, sync, wrap). Instantiated twice; inc for the vertical
//   axis = ce & horizontal wrap.
// TESTING
// - Reset, then ce=1 constant -> first edge gives hcount=0, vcount=0, frame_start=1,
//   hsync=0, vsync=0 (default polarity).
// - hcount 1055 -> next edge gives hcount=0, vcount+1, line_start=1.
//   hblnk=1 over 800..1055. hsync=1 exactly over 840..967 (128 cycles).
// - vcount 627 at hcount 1055 -> next edge gives (0,0) and frame_start=1.
//   vsync=1 over lines 601..604. Frame period = 663168 ce-cycles.
// - ce toggled 1/0 alternately -> all outputs hold on ce=0 edges. Line period = 2112 clk.
//   Each strobe is high for 2 clk.
// - H_SYNC_POL=0, V_SYNC_POL=0 -> reset hsync=vsync=1. hsync=0 over 840..967.
// - rst pulsed at hcount=500, vcount=300 -> outputs at reset values immediately.
//   After release, counting restarts at (0,0) with frame_start=1.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, state encoding and the timing bus payload
// consumed by downstream draw stages.
package vga_pkg;

  localparam int unsigned VGA_CNT_W = 11;

  // 800x600@60, 40 MHz pixel rate
  localparam int unsigned M800_H_ACTIVE     = 800;
  localparam int unsigned M800_H_SYNC_START = 840;
  localparam int unsigned M800_H_SYNC_END   = 968;
  localparam int unsigned M800_H_TOTAL      = 1056;
  localparam int unsigned M800_V_ACTIVE     = 600;
  localparam int unsigned M800_V_SYNC_START = 601;
  localparam int unsigned M800_V_SYNC_END   = 605;
  localparam int unsigned M800_V_TOTAL      = 628;
  localparam bit          M800_H_SYNC_POL   = 1'b1;
  localparam bit          M800_V_SYNC_POL   = 1'b1;

  // 1024x768@60, 65 MHz pixel rate, negative syncs
  localparam int unsigned M1024_H_ACTIVE     = 1024;
  localparam int unsigned M1024_H_SYNC_START = 1048;
  localparam int unsigned M1024_H_SYNC_END   = 1184;
  localparam int unsigned M1024_H_TOTAL      = 1344;
  localparam int unsigned M1024_V_ACTIVE     = 768;
  localparam int unsigned M1024_V_SYNC_START = 771;
  localparam int unsigned M1024_V_SYNC_END   = 777;
  localparam int unsigned M1024_V_TOTAL      = 806;
  localparam bit          M1024_H_SYNC_POL   = 1'b0;
  localparam bit          M1024_V_SYNC_POL   = 1'b0;

  typedef struct packed {
    logic [VGA_CNT_W-1:0] hcount;
    logic [VGA_CNT_W-1:0] vcount;
    logic                 hblnk;
    logic                 vblnk;
    logic                 hsync;
    logic                 vsync;
  } vga_timing_t;

  // ST_ARMED: waiting for the first enabled edge after reset to present (0,0)
  typedef enum logic {
    ST_ARMED = 1'b0,
    ST_RUN   = 1'b1
  } gen_state_e;

  function automatic bit axis_ok(input int unsigned active, input int unsigned sync_start,
                                 input int unsigned sync_end, input int unsigned total,
                                 input int unsigned cnt_w);
    return (active < sync_start) && (sync_start < sync_end) && (sync_end <= total) &&
           (64'(total) <= (64'd1 << cnt_w));
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter with blanking and sync flags decoded from
// the next count so they register alongside it.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned CNT_W      = 11,
  parameter int unsigned TOTAL      = 1056,
  parameter int unsigned ACTIVE     = 800,
  parameter int unsigned SYNC_START = 840,
  parameter int unsigned SYNC_END   = 968,
  parameter bit          POL        = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             blnk,
  output logic             sync,
  output logic             wrap
);

  if (!axis_ok(ACTIVE, SYNC_START, SYNC_END, TOTAL, CNT_W)) begin : g_bad_timing
    $error("vga_axis_counter: need ACTIVE < SYNC_START < SYNC_END <= TOTAL <= 2**CNT_W");
  end

  // One bit wider so SYNC_END/TOTAL equal to 2**CNT_W do not truncate
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W:0]   ACT_X   = (CNT_W+1)'(ACTIVE);
  localparam logic [CNT_W:0]   SS_X    = (CNT_W+1)'(SYNC_START);
  localparam logic [CNT_W:0]   SE_X    = (CNT_W+1)'(SYNC_END);

  logic [CNT_W-1:0] count_q, count_d;
  logic             blnk_q, blnk_d;
  logic             sync_q, sync_d;
  logic [CNT_W:0]   count_x;
  logic             in_sync_c;

  // Combinational: true while the current count is the last of the axis
  assign wrap = (count_q == LAST);

  always_comb begin
    count_d   = count_q;
    blnk_d    = blnk_q;
    sync_d    = sync_q;
    count_x   = '0;
    in_sync_c = 1'b0;
    if (start) begin
      count_d = '0;
    end else if (inc) begin
      count_d = wrap ? '0 : count_q + CNT_W'(1);
    end
    if (start || inc) begin
      count_x   = {1'b0, count_d};
      in_sync_c = (count_x >= SS_X) && (count_x < SE_X);
      blnk_d    = (count_x >= ACT_X);
      sync_d    = in_sync_c ? POL : ~POL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      blnk_q  <= 1'b0;
      sync_q  <= ~POL;
    end else begin
      count_q <= count_d;
      blnk_q  <= blnk_d;
      sync_q  <= sync_d;
    end
  end

  assign count = count_q;
  assign blnk  = blnk_q;
  assign sync  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel/line counters, blanking, sync and
// line/frame start strobes, all registered and advanced by the pixel enable.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CNT_W        = VGA_CNT_W,
  parameter int unsigned H_ACTIVE     = M800_H_ACTIVE,
  parameter int unsigned H_SYNC_START = M800_H_SYNC_START,
  parameter int unsigned H_SYNC_END   = M800_H_SYNC_END,
  parameter int unsigned H_TOTAL      = M800_H_TOTAL,
  parameter int unsigned V_ACTIVE     = M800_V_ACTIVE,
  parameter int unsigned V_SYNC_START = M800_V_SYNC_START,
  parameter int unsigned V_SYNC_END   = M800_V_SYNC_END,
  parameter int unsigned V_TOTAL      = M800_V_TOTAL,
  parameter bit          H_SYNC_POL   = M800_H_SYNC_POL,
  parameter bit          V_SYNC_POL   = M800_V_SYNC_POL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hblnk,
  output logic             vblnk,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start
);

  gen_state_e state_q, state_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       start_c;
  logic       h_wrap_c, v_wrap_c;
  logic       v_inc_c;

  // First enabled edge after reset reloads (0,0) instead of incrementing
  always_comb begin
    state_d       = state_q;
    start_c       = 1'b0;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    case (state_q)
      ST_ARMED: begin
        if (ce) begin
          start_c = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_ARMED;
    endcase
    if (ce) begin
      line_start_d  = start_c | h_wrap_c;
      frame_start_d = start_c | (h_wrap_c & v_wrap_c);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_ARMED;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign v_inc_c = ce & h_wrap_c;

  vga_axis_counter #(
    .CNT_W      (CNT_W),
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_SYNC_START),
    .SYNC_END   (H_SYNC_END),
    .POL        (H_SYNC_POL)
  ) u_h_axis (
    .clk   (clk),
    .rst   (rst),
    .start (start_c),
    .inc   (ce),
    .count (hcount),
    .blnk  (hblnk),
    .sync  (hsync),
    .wrap  (h_wrap_c)
  );

  vga_axis_counter #(
    .CNT_W      (CNT_W),
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_SYNC_START),
    .SYNC_END   (V_SYNC_END),
    .POL        (V_SYNC_POL)
  ) u_v_axis (
    .clk   (clk),
    .rst   (rst),
    .start (start_c),
    .inc   (v_inc_c),
    .count (vcount),
    .blnk  (vblnk),
    .sync  (vsync),
    .wrap  (v_wrap_c)
  );

  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 800x600 mode, the same mode with negative syncs, and
// a tiny 8x6 mode that makes whole frames short enough to walk through.
module tb_vga_timing_gen;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic ce;

  logic [10:0] d_hc, d_vc, n_hc, n_vc;
  logic        d_hb, d_vb, d_hs, d_vs, d_ls, d_fs;
  logic        n_hb, n_vb, n_hs, n_vs, n_ls, n_fs;
  logic [3:0]  s_hc, s_vc;
  logic        s_hb, s_vb, s_hs, s_vs, s_ls, s_fs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_dut (
    .clk(clk), .rst(rst), .ce(ce), .hcount(d_hc), .vcount(d_vc), .hblnk(d_hb), .vblnk(d_vb),
    .hsync(d_hs), .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing_gen #(.H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)) u_neg (
    .clk(clk), .rst(rst), .ce(ce), .hcount(n_hc), .vcount(n_vc), .hblnk(n_hb), .vblnk(n_vb),
    .hsync(n_hs), .vsync(n_vs), .line_start(n_ls), .frame_start(n_fs)
  );

  vga_timing_gen #(
    .CNT_W(4), .H_ACTIVE(4), .H_SYNC_START(5), .H_SYNC_END(7), .H_TOTAL(8),
    .V_ACTIVE(3), .V_SYNC_START(4), .V_SYNC_END(5), .V_TOTAL(6)
  ) u_small (
    .clk(clk), .rst(rst), .ce(ce), .hcount(s_hc), .vcount(s_vc), .hblnk(s_hb), .vblnk(s_vb),
    .hsync(s_hs), .vsync(s_vs), .line_start(s_ls), .frame_start(s_fs)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vga_timing_t mk(input int unsigned h, input int unsigned v,
                                     input logic hb, input logic vb,
                                     input logic hs, input logic vs);
    vga_timing_t t;
    t.hcount = VGA_CNT_W'(h);
    t.vcount = VGA_CNT_W'(v);
    t.hblnk  = hb;
    t.vblnk  = vb;
    t.hsync  = hs;
    t.vsync  = vs;
    return t;
  endfunction

  function automatic vga_timing_t obs_d();
    return mk(int'(d_hc), int'(d_vc), d_hb, d_vb, d_hs, d_vs);
  endfunction

  function automatic vga_timing_t obs_n();
    return mk(int'(n_hc), int'(n_vc), n_hb, n_vb, n_hs, n_vs);
  endfunction

  function automatic vga_timing_t obs_s();
    return mk(int'(s_hc), int'(s_vc), s_hb, s_vb, s_hs, s_vs);
  endfunction

  initial begin
    vga_timing_t pd, ps;
    logic [1:0]  pls, pss;
    int          hs_cnt, fs_cnt, ls_hi, rise0, rise1, sh, sv;

    rst = 1'b1;
    ce  = 1'b0;
    repeat (3) tick();
    check("reset_dut",  64'(obs_d()), 64'(mk(0, 0, 0, 0, 0, 0)));
    check("reset_strb", 64'({d_ls, d_fs}), 64'(2'b00));
    check("reset_neg",  64'(obs_n()), 64'(mk(0, 0, 0, 0, 1, 1)));
    check("reset_small", 64'(obs_s()), 64'(mk(0, 0, 0, 0, 0, 0)));

    rst = 1'b0;
    ce  = 1'b1;
    tick();
    check("first_dut",   64'(obs_d()), 64'(mk(0, 0, 0, 0, 0, 0)));
    check("first_strb",  64'({d_ls, d_fs}), 64'(2'b11));
    check("first_neg",   64'(obs_n()), 64'(mk(0, 0, 0, 0, 1, 1)));
    check("first_small", 64'({s_ls, s_fs}), 64'(2'b11));

    // Walk the first full line; the small mode runs 22 frames alongside
    hs_cnt = 0;
    fs_cnt = 1;
    for (int i = 1; i < 1056; i++) begin
      tick();
      check("line_h",   64'(d_hc), 64'(i));
      check("line_v",   64'(d_vc), 64'(0));
      check("line_hb",  64'(d_hb), 64'(i >= 800));
      check("line_hs",  64'(d_hs), 64'(i >= 840 && i < 968));
      check("line_str", 64'({d_ls, d_fs}), 64'(2'b00));
      check("neg_hs",   64'(n_hs), 64'(!(i >= 840 && i < 968)));
      check("neg_vs",   64'(n_vs), 64'(1));
      sh = i % 8;
      sv = (i / 8) % 6;
      check("small_t",  64'(obs_s()),
            64'(mk(sh, sv, sh >= 4, sv >= 3, sh >= 5 && sh < 7, sv == 4)));
      check("small_ls", 64'(s_ls), 64'(sh == 0));
      check("small_fs", 64'(s_fs), 64'(i % 48 == 0));
      if (d_hs) hs_cnt++;
      if (s_fs) fs_cnt++;
    end
    check("hsync_width", 64'(hs_cnt), 64'(128));

    tick();
    check("hwrap_dut",  64'(obs_d()), 64'(mk(0, 1, 0, 0, 0, 0)));
    check("hwrap_strb", 64'({d_ls, d_fs}), 64'(2'b10));
    check("fwrap_small", 64'(obs_s()), 64'(mk(0, 0, 0, 0, 0, 0)));
    check("fwrap_strb", 64'({s_ls, s_fs}), 64'(2'b11));
    if (s_fs) fs_cnt++;
    check("small_frames", 64'(fs_cnt), 64'(23));

    // Alternate ce 0/1: hold on ce=0 edges, two lines take 4224 clk
    ls_hi = 0;
    rise0 = -1;
    rise1 = -1;
    for (int j = 0; j < 4224; j++) begin
      ce  = 1'(j % 2);
      pd  = obs_d();
      ps  = obs_s();
      pls = {d_ls, d_fs};
      pss = {s_ls, s_fs};
      tick();
      if (!ce) begin
        check("hold_dut",   64'(obs_d()), 64'(pd));
        check("hold_strb",  64'({d_ls, d_fs}), 64'(pls));
        check("hold_small", 64'(obs_s()), 64'(ps));
        check("hold_sstrb", 64'({s_ls, s_fs}), 64'(pss));
      end
      if (d_ls) begin
        ls_hi++;
        if (!pls[1]) begin
          if (rise0 < 0) rise0 = j;
          else rise1 = j;
        end
      end
    end
    check("ls_samples",  64'(ls_hi), 64'(4));
    check("ls_rise0",    64'(rise0), 64'(2111));
    check("line_period", 64'(rise1 - rise0), 64'(2112));
    check("ce_end_dut",  64'(obs_d()), 64'(mk(0, 3, 0, 0, 0, 0)));
    check("ce_end_small", 64'({s_ls, s_fs}), 64'(2'b11));

    // Mid-line reset is asynchronous, then counting restarts at (0,0)
    ce = 1'b1;
    repeat (500) tick();
    check("pre_rst_dut", 64'(obs_d()), 64'(mk(500, 3, 0, 0, 0, 0)));
    rst = 1'b1;
    #1;
    check("async_dut",   64'(obs_d()), 64'(mk(0, 0, 0, 0, 0, 0)));
    check("async_strb",  64'({d_ls, d_fs}), 64'(2'b00));
    check("async_neg",   64'(obs_n()), 64'(mk(0, 0, 0, 0, 1, 1)));
    check("async_small", 64'(obs_s()), 64'(mk(0, 0, 0, 0, 0, 0)));
    tick();
    rst = 1'b0;
    tick();
    check("restart_dut",  64'(obs_d()), 64'(mk(0, 0, 0, 0, 0, 0)));
    check("restart_strb", 64'({d_ls, d_fs}), 64'(2'b11));
    tick();
    check("restart_h1",   64'(obs_d()), 64'(mk(1, 0, 0, 0, 0, 0)));
    check("restart_clr",  64'({d_ls, d_fs}), 64'(2'b00));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
